// File: rtl/render_pkg.sv
// Shared constants for the layer renderer: colours, glyph geometry, digit placement.
package render_pkg;

    localparam int GLYPH_W     = 8;
    localparam int GLYPH_H     = 12;
    localparam int GEOM_W      = 11;

    // Digit origins are offsets from the horizontal centre of the active area.
    localparam int DIGIT_L_OFS = 60;
    localparam int DIGIT_R_OFS = 36;
    localparam int DIGIT_Y     = 20;

    localparam logic [23:0] RGB_BLACK  = 24'h000000;
    localparam logic [23:0] DEF_BG_RGB = 24'h000040;
    localparam logic [23:0] DEF_FG_RGB = 24'hFFFFFF;

endpackage

// File: rtl/glyph_rom.sv
// Combinational 8x12 digit font; codes 10..15 and rows past 11 read as blank.
module glyph_rom
    import render_pkg::*;
(
    input  logic [3:0]         digit,
    input  logic [3:0]         row,
    output logic [GLYPH_W-1:0] bits
);

    logic [8*GLYPH_H-1:0] rows;

    // Row 0 sits in the most significant byte; bit 7 of a row is the leftmost pixel.
    always_comb begin
        rows = '0;
        case (digit)
            4'd0: rows = {8'h00, 8'h7C, 8'hC6, 8'hCE, 8'hDE, 8'hF6, 8'hE6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00};
            4'd1: rows = {8'h00, 8'h18, 8'h38, 8'h78, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00};
            4'd2: rows = {8'h00, 8'h7C, 8'hC6, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'hC6, 8'hFE, 8'h00};
            4'd3: rows = {8'h00, 8'h7C, 8'hC6, 8'h06, 8'h06, 8'h3C, 8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C, 8'h00};
            4'd4: rows = {8'h00, 8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'hCC, 8'hFE, 8'h0C, 8'h0C, 8'h0C, 8'h1E, 8'h00};
            4'd5: rows = {8'h00, 8'hFE, 8'hC0, 8'hC0, 8'hFC, 8'h06, 8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C, 8'h00};
            4'd6: rows = {8'h00, 8'h38, 8'h60, 8'hC0, 8'hFC, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00};
            4'd7: rows = {8'h00, 8'hFE, 8'hC6, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h00};
            4'd8: rows = {8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00};
            4'd9: rows = {8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7E, 8'h06, 8'h06, 8'h06, 8'h0C, 8'h78, 8'h00};
            default: rows = '0;
        endcase
        bits = '0;
        if (row < 4'd12)
            bits = rows[8*GLYPH_H-1 - 8*row -: 8];
    end

endmodule

// File: rtl/layer_renderer.sv
// Two-stage overlay renderer: border, two score digits and NUM_OBJ rectangles over a background.
// Optional SCORE_FLASH_EN blinks a digit for FLASH_FRAMES frames after its score changes.
module layer_renderer
    import render_pkg::*;
#(
    parameter int          H_ACTIVE     = 1280,
    parameter int          V_ACTIVE     = 720,
    parameter int          NUM_OBJ      = 3,
    parameter int          BORDER       = 8,
    parameter int          SCALE        = 2,
    parameter int          FLASH_FRAMES = 32,
    parameter logic [23:0] BG_RGB       = DEF_BG_RGB,
    parameter logic [23:0] FG_RGB       = DEF_FG_RGB
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [11:0]               hcount,
    input  logic [11:0]               vcount,
    input  logic                      de_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic [GEOM_W*NUM_OBJ-1:0] obj_x,
    input  logic [GEOM_W*NUM_OBJ-1:0] obj_y,
    input  logic [GEOM_W*NUM_OBJ-1:0] obj_w,
    input  logic [GEOM_W*NUM_OBJ-1:0] obj_h,
    input  logic [24*NUM_OBJ-1:0]     obj_rgb,
    input  logic [3:0]                score_l,
    input  logic [3:0]                score_r,
    output logic [23:0]               rgb,
    output logic                      de_out,
    output logic                      hsync_out,
    output logic                      vsync_out
);

    localparam logic [11:0] HA  = 12'(H_ACTIVE);
    localparam logic [11:0] VA  = 12'(V_ACTIVE);
    localparam logic [11:0] BRD = 12'(BORDER);
    localparam logic [11:0] LX  = 12'(H_ACTIVE/2 - DIGIT_L_OFS);
    localparam logic [11:0] RX  = 12'(H_ACTIVE/2 + DIGIT_R_OFS);
    localparam logic [11:0] DY  = 12'(DIGIT_Y);
    localparam logic [11:0] GW  = 12'(GLYPH_W*SCALE);
    localparam logic [11:0] GH  = 12'(GLYPH_H*SCALE);
    localparam logic [11:0] SC  = 12'(SCALE);

    logic [GEOM_W*NUM_OBJ-1:0] sh_x, sh_y, sh_w, sh_h;
    logic [24*NUM_OBJ-1:0]     sh_rgb;
    logic [3:0]                sh_score_l, sh_score_r;
    logic                      load;
    logic                      show_l, show_r;

    // Shadow load happens on the first blanking line so the visible frame never tears.
    assign load = (vcount == VA) && (hcount == 12'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x       <= '0;
            sh_y       <= '0;
            sh_w       <= '0;
            sh_h       <= '0;
            sh_rgb     <= '0;
            sh_score_l <= '0;
            sh_score_r <= '0;
        end else if (load) begin
            sh_x       <= obj_x;
            sh_y       <= obj_y;
            sh_w       <= obj_w;
            sh_h       <= obj_h;
            sh_rgb     <= obj_rgb;
            sh_score_l <= score_l;
            sh_score_r <= score_r;
        end
    end

`ifdef SCORE_FLASH_EN
    localparam int FW = ($clog2(FLASH_FRAMES + 1) < 3) ? 3 : $clog2(FLASH_FRAMES + 1);

    logic [FW-1:0] flash_l, flash_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_l <= '0;
            flash_r <= '0;
        end else if (load) begin
            if (score_l != sh_score_l)
                flash_l <= FW'(FLASH_FRAMES);
            else if (flash_l != '0)
                flash_l <= flash_l - 1'b1;
            if (score_r != sh_score_r)
                flash_r <= FW'(FLASH_FRAMES);
            else if (flash_r != '0)
                flash_r <= flash_r - 1'b1;
        end
    end

    assign show_l = (flash_l == '0) || flash_l[2];
    assign show_r = (flash_r == '0) || flash_r[2];
`else
    assign show_l = 1'b1;
    assign show_r = 1'b1;
`endif

    logic [NUM_OBJ-1:0] hit_d;
    logic               border_d, in_y_d, in_l_d, in_r_d;
    logic [11:0]        dy, dx_l, dx_r;

    // Widening to 12 bits keeps x+w and y+h from wrapping.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            hit_d[i] = (hcount >= {1'b0, sh_x[GEOM_W*i +: GEOM_W]})
                    && (hcount <  {1'b0, sh_x[GEOM_W*i +: GEOM_W]} + {1'b0, sh_w[GEOM_W*i +: GEOM_W]})
                    && (vcount >= {1'b0, sh_y[GEOM_W*i +: GEOM_W]})
                    && (vcount <  {1'b0, sh_y[GEOM_W*i +: GEOM_W]} + {1'b0, sh_h[GEOM_W*i +: GEOM_W]});
        end
    end

    assign border_d = (BORDER != 0)
                   && ((hcount < BRD) || (hcount >= HA - BRD) || (vcount < BRD) || (vcount >= VA - BRD));
    assign in_y_d   = (vcount >= DY) && (vcount < DY + GH);
    assign in_l_d   = in_y_d && (hcount >= LX) && (hcount < LX + GW);
    assign in_r_d   = in_y_d && (hcount >= RX) && (hcount < RX + GW);
    assign dy       = vcount - DY;
    assign dx_l     = hcount - LX;
    assign dx_r     = hcount - RX;

    logic [NUM_OBJ-1:0] s1_hit;
    logic               s1_border, s1_in_l, s1_in_r, s1_de, s1_hs, s1_vs;
    logic [3:0]         s1_row;
    logic [2:0]         s1_col_l, s1_col_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit    <= '0;
            s1_border <= 1'b0;
            s1_in_l   <= 1'b0;
            s1_in_r   <= 1'b0;
            s1_row    <= '0;
            s1_col_l  <= '0;
            s1_col_r  <= '0;
            s1_de     <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
        end else begin
            s1_hit    <= hit_d;
            s1_border <= border_d;
            s1_in_l   <= in_l_d;
            s1_in_r   <= in_r_d;
            s1_row    <= 4'(dy / SC);
            s1_col_l  <= 3'(dx_l / SC);
            s1_col_r  <= 3'(dx_r / SC);
            s1_de     <= de_in;
            s1_hs     <= hsync_in;
            s1_vs     <= vsync_in;
        end
    end

    logic [GLYPH_W-1:0] pat_l, pat_r;
    logic               lit_l, lit_r;
    logic [23:0]        obj_col, rgb_d;

    glyph_rom u_glyph_l (.digit(sh_score_l), .row(s1_row), .bits(pat_l));
    glyph_rom u_glyph_r (.digit(sh_score_r), .row(s1_row), .bits(pat_r));

    assign lit_l = s1_in_l && show_l && pat_l[3'd7 - s1_col_l];
    assign lit_r = s1_in_r && show_r && pat_r[3'd7 - s1_col_r];

    // Walking from the top index down leaves the lowest-index hit in obj_col.
    always_comb begin
        obj_col = BG_RGB;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (s1_hit[i])
                obj_col = sh_rgb[24*i +: 24];
        end
    end

    always_comb begin
        rgb_d = obj_col;
        if (!s1_de)
            rgb_d = RGB_BLACK;
        else if (s1_border || lit_l || lit_r)
            rgb_d = FG_RGB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb       <= RGB_BLACK;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb       <= rgb_d;
            de_out    <= s1_de;
            hsync_out <= s1_hs;
            vsync_out <= s1_vs;
        end
    end

endmodule

// File: tb/tb_layer_renderer.sv
// Self-checking bench for layer_renderer: pixel vector tables scored through a 2-deep latency queue.
module tb_layer_renderer;
    import render_pkg::*;

    localparam int N = 3;
    localparam logic [23:0] BG = 24'h000040;
    localparam logic [23:0] FG = 24'hFFFFFF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [11:0]       hcount, vcount;
    logic              de_in, hsync_in, vsync_in;
    logic [11*N-1:0]   obj_x, obj_y, obj_w, obj_h;
    logic [24*N-1:0]   obj_rgb;
    logic [3:0]        score_l, score_r;
    logic [23:0]       rgb;
    logic              de_out, hsync_out, vsync_out;

    layer_renderer dut (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h), .obj_rgb(obj_rgb),
        .score_l(score_l), .score_r(score_r),
        .rgb(rgb), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic        de;
        logic [23:0] rgb;
    } vec_t;

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t tab[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (sb.size() == 3) begin
            e = sb.pop_front();
            checks++;
            if (rgb !== e.rgb || de_out !== e.de || hsync_out !== e.hs || vsync_out !== e.vs) begin
                errors++;
                $display("FAIL pixel(%0d,%0d): got rgb=%h de=%b hs=%b vs=%b, want rgb=%h de=%b hs=%b vs=%b",
                         e.h, e.v, rgb, de_out, hsync_out, vsync_out, e.rgb, e.de, e.hs, e.vs);
            end
        end
    end

    task automatic step(input logic [11:0] h, input logic [11:0] v, input logic de,
                        input logic hs, input logic vs, input logic [23:0] exp_rgb);
        hcount   = h;
        vcount   = v;
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
        sb.push_back('{h, v, exp_rgb, de, hs, vs});
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int h, input int v, input logic de, input logic [23:0] c);
        tab.push_back('{12'(h), 12'(v), de, c});
    endtask

    task automatic run_tab();
        for (int i = 0; i < tab.size(); i++)
            step(tab[i].h, tab[i].v, tab[i].de, (i % 2) == 1, (i % 3) == 2, tab[i].de ? tab[i].rgb : 24'h0);
        tab.delete();
    endtask

    task automatic frame_load();
        step(12'd0, 12'd720, 1'b0, 1'b0, 1'b1, 24'h0);
    endtask

    task automatic set_obj(input int i, input int x, input int y, input int w, input int h,
                           input logic [23:0] c);
        obj_x[11*i +: 11]   = 11'(x);
        obj_y[11*i +: 11]   = 11'(y);
        obj_w[11*i +: 11]   = 11'(w);
        obj_h[11*i +: 11]   = 11'(h);
        obj_rgb[24*i +: 24] = c;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (rgb !== 24'h0 || de_out !== 1'b0 || hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
            errors++;
            $display("FAIL %s: got rgb=%h de=%b hs=%b vs=%b, want all zero",
                     name, rgb, de_out, hsync_out, vsync_out);
        end
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        hcount = '0; vcount = '0; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        obj_x = '0; obj_y = '0; obj_w = '0; obj_h = '0; obj_rgb = '0;
        score_l = '0; score_r = '0;
        repeat (2) @(posedge clk);
        #1;
        hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b1;
        check_zero("reset_state");
        rst_n = 1'b1;

        // Frame A: single object, overlap pair, clipped object near the corner.
        set_obj(0, 100, 200, 12, 100, 24'hFFFFFF);
        set_obj(1, 290, 290, 20, 20, 24'hFF0000);
        set_obj(2, 1270, 700, 100, 100, 24'h00FF00);
        score_l = 4'd3;
        score_r = 4'd12;
        frame_load();

        add(100, 200, 1, 24'hFFFFFF);
        add(111, 299, 1, 24'hFFFFFF);
        add(112, 200, 1, BG);
        add(99,  200, 1, BG);
        add(111, 300, 1, BG);
        add(100, 200, 0, 24'h0);
        add(0,   400, 1, FG);
        add(7,   400, 1, FG);
        add(8,   400, 1, BG);
        add(1271, 400, 1, BG);
        add(1272, 400, 1, FG);
        add(640, 7,   1, FG);
        add(640, 8,   1, BG);
        add(640, 711, 1, BG);
        add(640, 712, 1, FG);
        add(300, 300, 1, 24'hFF0000);
        add(1271, 705, 1, 24'h00FF00);
        add(582, 22,  1, FG);
        add(580, 20,  1, BG);
        add(580, 24,  1, FG);
        add(580, 26,  1, BG);
        add(590, 26,  1, FG);
        add(596, 24,  1, BG);
        add(587, 42,  1, BG);
        add(585, 44,  1, BG);
        add(678, 22,  1, BG);
        add(676, 24,  1, BG);
        add(690, 26,  1, BG);
        run_tab();

        // Mid-frame change: geometry and score move only at the next load.
        step(12'd100, 12'd360, 1'b1, 1'b0, 1'b0, BG);
        set_obj(0, 400, 200, 12, 100, 24'hFFFFFF);
        score_l = 4'd8;
        add(100, 250, 1, 24'hFFFFFF);
        add(405, 250, 1, BG);
        add(580, 26,  1, BG);
        add(100, 719, 1, FG);
        run_tab();
        frame_load();
        add(405, 250, 1, 24'hFFFFFF);
        add(100, 250, 1, BG);
        add(580, 26,  1, FG);
        add(405, 250, 1, 24'hFFFFFF);
        add(405, 250, 1, 24'hFFFFFF);
        run_tab();

        // Reset mid-line: outputs clear at once, shadows empty until the next load.
        mid_reset();
        add(405, 250, 1, BG);
        add(582, 22,  1, FG);
        add(1,   1,   1, FG);
        add(300, 300, 1, BG);
        run_tab();

        set_obj(0, 290, 290, 20, 20, 24'hFF0000);
        set_obj(1, 295, 295, 20, 20, 24'h00FF00);
        set_obj(2, 500, 500, 0, 50, 24'h123456);
        frame_load();
        add(300, 300, 1, 24'hFF0000);
        add(312, 312, 1, 24'h00FF00);
        add(500, 500, 1, BG);
        add(405, 250, 1, BG);
        add(289, 300, 1, BG);
        run_tab();

        step(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 24'h0);
        step(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 24'h0);
        step(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 24'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_renderer.md
LAYER_RENDERER -- requirements
Module: layer_renderer

Interface
REQ-001 Parameter H_ACTIVE, 1280, visible pixels per line.
REQ-002 Parameter V_ACTIVE, 720, visible lines per frame.
REQ-003 Parameter NUM_OBJ, 3, number of rectangle objects (1..8).
REQ-004 Parameter BORDER, 8, border thickness in pixels; 0 disables the border.
REQ-005 Parameter SCALE, 2, integer magnification of the 8x12 score glyph (1..4).
REQ-006 Parameter FLASH_FRAMES, 32, frames a changed score blinks.
REQ-007 Parameter BG_RGB, 24'h000040, background colour; FG_RGB, 24'hFFFFFF, border and score colour.
REQ-008 clk  in  1  pixel clock; the block has one clock.
REQ-009 rst_n  in  1  reset, asynchronous and active-low.
REQ-010 hcount, vcount  in  12 each  current pixel position.
REQ-011 de_in, hsync_in, vsync_in  in  1 each  timing strobes aligned with hcount/vcount.
REQ-012 obj_x, obj_y, obj_w, obj_h  in  11*NUM_OBJ each  packed object geometry; object i in bits [11i+10:11i].
REQ-013 obj_rgb  in  24*NUM_OBJ  packed object colours.
REQ-014 score_l, score_r  in  4 each  player scores.
REQ-015 rgb  out  24  pixel colour; de_out, hsync_out, vsync_out  out  1 each  delayed strobes.

Function
REQ-016 Geometry and scores SHALL be copied into shadow registers in the cycle where vcount==V_ACTIVE and hcount==0; rendering SHALL use shadow values only, so no tearing occurs mid-frame.
REQ-017 Pipeline latency SHALL be exactly 2 cycles: rgb, de_out, hsync_out and vsync_out for input cycle n SHALL appear at cycle n+2.
REQ-018 Stage 1 SHALL register per-object hit flags, border hit, glyph row/column and de; stage 2 SHALL register the resolved colour.
REQ-019 Priority SHALL be: de low -> 24'h000000; border; score pixel -> FG_RGB; lowest-index hit object -> its obj_rgb; else BG_RGB.
REQ-020 Object i hit SHALL be x<=hcount<x+w and y<=vcount<y+h, compared at 12 bits so x+w never wraps; w==0 or h==0 SHALL draw nothing; extents beyond the active area SHALL clip.
REQ-021 Left digit origin SHALL be (H_ACTIVE/2-60, 20), right digit (H_ACTIVE/2+36, 20); each glyph covers 8*SCALE by 12*SCALE pixels.
REQ-022 Score values 10..15 SHALL render blank.
REQ-023 Border SHALL cover hcount<BORDER, hcount>=H_ACTIVE-BORDER, vcount<BORDER, vcount>=V_ACTIVE-BORDER.

Reset
REQ-024 While rst_n is low: rgb=0, de_out=hsync_out=vsync_out=0, all shadow geometry=0 (nothing drawn), shadow scores=0, flash counters=0.
REQ-025 After reset mid-frame, output SHALL be border/score 0/background only until the next shadow load.

Configuration
REQ-026 With SCORE_FLASH_EN defined: at shadow load, if a new score differs from its shadow, that side's counter SHALL load FLASH_FRAMES and decrement once per later load; while nonzero, that digit SHALL be shown only when counter bit 2 is 1.
REQ-027 Without SCORE_FLASH_EN: counters SHALL not exist and digits SHALL always show.

Structure
REQ-028 Package render_pkg SHALL hold colour constants, glyph dimensions (8, 12), digit origin offsets and the object-geometry width (11).
REQ-029 Sub-module glyph_rom SHALL map (digit, row) to an 8-bit row pattern combinationally; two instances, one per side.

Verification
REQ-030 Object 0 at (100,200) size 12x100, colour FFFFFF: pixel (100,200) -> rgb FFFFFF two cycles later; (112,200) -> BG_RGB.
REQ-031 Objects 0 and 1 overlap at (300,300) with colours FF0000/00FF00 -> rgb FF0000.
REQ-032 Change obj_x mid-frame at line 360 -> lines 360..719 unchanged; new position appears from next frame.
REQ-033 score_l=3, SCALE=2 -> glyph pixels at x 580..595, y 20..43 are FG_RGB; score_l=12 -> none lit.
REQ-034 SCORE_FLASH_EN, score_r 0->1 -> right digit blinks for 32 frames (4 off, 4 on), steady afterwards; left never blinks.
REQ-035 rst_n low for 1 cycle mid-line -> all outputs 0 immediately; no object drawn until the next shadow load.
